pkt_tx_ingress_fifo: RTL and testbench

Parametrised ingress stage for the MAC transmit packet interface (sop/eop/mod/val/full). It accepts words from the host, checks sop/eop framing and buffers words in a FIFO. It drives pkt_tx_full early using a programmable margin, so upstream latency cannot overflow the FIFO. It presents a valid/ready stream to the TX datapath with a per-word error tag, plus saturating packet and error counters.

---
 rtl/pkt_tx_pkg.sv | 22 ++
 rtl/pkt_sync_fifo.sv | 51 +++++
 rtl/pkt_tx_ingress_fifo.sv | 155 +++++++++++++++
 tb/tb_pkt_tx_ingress_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_pkg.sv
// Shared types for the MAC TX ingress FIFO: framing FSM state, per-entry control flags
// and the byte-count width helper.
package pkt_tx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

  // Control flags stored alongside each data word. The full FIFO entry is assembled in the
  // top level, because its data and mod widths depend on the instance parameters.
  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
  } entry_ctl_t;

  function automatic int mod_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Generic synchronous FIFO with a combinational read port, so a word written at one edge
// is visible right after that edge. Pointers carry one extra wrap bit.
module pkt_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      occupancy,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // The pointers are equal at their low bits both when empty and when full; the wrap bit
  // tells the two cases apart.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;

  // A write is judged against the occupancy before the edge.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pkt_tx_ingress_fifo.sv
// MAC TX ingress stage: checks host sop/eop framing, buffers words, and drives early
// backpressure (pkt_tx_full). It also keeps saturating packet and error counters.
//
// state  | meaning
// IDLE   | between packets; only a sop word is accepted
// IN_PKT | inside a packet; words are stored until eop
module pkt_tx_ingress_fifo
  import pkt_tx_pkg::*;
#(
  parameter  int DATA_W      = 64,
  parameter  int DEPTH       = 16,
  parameter  int FULL_MARGIN = 2,
  parameter  int CNT_W       = 16,
  localparam int MOD_W       = mod_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pkt_tx_data,
  input  logic              pkt_tx_sop,
  input  logic              pkt_tx_eop,
  input  logic [MOD_W-1:0]  pkt_tx_mod,
  input  logic              pkt_tx_val,
  output logic              pkt_tx_full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [MOD_W-1:0]  out_mod,
  output logic              out_err,
  output logic              out_val,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              ovf_sticky
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [AW:0] FULL_THRESH = (AW+1)'(DEPTH - FULL_MARGIN);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
    entry_ctl_t        ctl;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  frame_state_t state;
  frame_state_t state_next;
  logic         store_req;
  logic         orphan;
  logic         restart;
  logic         store_ok;
  logic         drop;
  logic         err_evt;
  logic         rd_fire;
  entry_t       wr_entry;
  entry_t       rd_entry;
  logic [AW:0]  occupancy;
  logic [AW:0]  occ_next;
  logic         fifo_full;
  logic         fifo_empty;

  always_comb begin
    state_next = state;
    store_req  = 1'b0;
    orphan     = 1'b0;
    restart    = 1'b0;
    if (pkt_tx_val) begin
      case (state)
        IDLE: begin
          if (pkt_tx_sop) begin
            store_req = 1'b1;
            if (!pkt_tx_eop) state_next = IN_PKT;
          end else begin
            orphan = 1'b1;
          end
        end
        IN_PKT: begin
          store_req = 1'b1;
          restart   = pkt_tx_sop;
          if (pkt_tx_eop) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A word dropped on overflow still advances the FSM, so the framing stays in step with
  // the host.
  assign store_ok = store_req & ~fifo_full;
  assign drop     = store_req & fifo_full;
  assign err_evt  = orphan | restart | drop;
  assign rd_fire  = out_val & out_ready;

  always_comb begin
    wr_entry         = '0;
    wr_entry.data    = pkt_tx_data;
    wr_entry.mod     = pkt_tx_mod;
    wr_entry.ctl.sop = pkt_tx_sop;
    wr_entry.ctl.eop = pkt_tx_eop;
    wr_entry.ctl.err = restart;
  end

  pkt_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (store_req),
    .wr_data   (wr_entry),
    .rd_en     (out_ready),
    .rd_data   (rd_entry),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign occ_next = occupancy + (AW+1)'(store_ok) - (AW+1)'(rd_fire);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pkt_tx_full <= 1'b0;
      pkt_cnt     <= '0;
      err_cnt     <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      state       <= state_next;
      pkt_tx_full <= (occ_next >= FULL_THRESH);
      if (drop) ovf_sticky <= 1'b1;
      if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      if (store_ok && pkt_tx_eop && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

  // Force the output fields to zero while nothing is valid, so stale RAM contents never
  // leak onto the bus.
  always_comb begin
    out_val  = ~fifo_empty;
    out_data = '0;
    out_mod  = '0;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    out_err  = 1'b0;
    if (out_val) begin
      out_data = rd_entry.data;
      out_mod  = rd_entry.mod;
      out_sop  = rd_entry.ctl.sop;
      out_eop  = rd_entry.ctl.eop;
      out_err  = rd_entry.ctl.err;
    end
  end

endmodule

// File: tb/tb_pkt_tx_ingress_fifo.sv
// Directed bench for pkt_tx_ingress_fifo: a default build (64b, depth 16) and a small
// build (32b, depth 4, 2-bit counters).
module tb_pkt_tx_ingress_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [63:0] a_data;
  logic        a_sop, a_eop, a_val, a_ready;
  logic [2:0]  a_mod;
  logic        a_full, a_out_sop, a_out_eop, a_out_err, a_out_val, a_ovf;
  logic [63:0] a_out_data;
  logic [2:0]  a_out_mod;
  logic [15:0] a_pkt_cnt, a_err_cnt;

  logic [31:0] b_data;
  logic        b_sop, b_eop, b_val, b_ready;
  logic [1:0]  b_mod;
  logic        b_full, b_out_sop, b_out_eop, b_out_err, b_out_val, b_ovf;
  logic [31:0] b_out_data;
  logic [1:0]  b_out_mod;
  logic [1:0]  b_pkt_cnt, b_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_tx_ingress_fifo dut_a (
    .clk(clk), .reset_n(reset_n),
    .pkt_tx_data(a_data), .pkt_tx_sop(a_sop), .pkt_tx_eop(a_eop), .pkt_tx_mod(a_mod),
    .pkt_tx_val(a_val), .pkt_tx_full(a_full),
    .out_data(a_out_data), .out_sop(a_out_sop), .out_eop(a_out_eop), .out_mod(a_out_mod),
    .out_err(a_out_err), .out_val(a_out_val), .out_ready(a_ready),
    .pkt_cnt(a_pkt_cnt), .err_cnt(a_err_cnt), .ovf_sticky(a_ovf)
  );

  pkt_tx_ingress_fifo #(.DATA_W(32), .DEPTH(4), .FULL_MARGIN(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .pkt_tx_data(b_data), .pkt_tx_sop(b_sop), .pkt_tx_eop(b_eop), .pkt_tx_mod(b_mod),
    .pkt_tx_val(b_val), .pkt_tx_full(b_full),
    .out_data(b_out_data), .out_sop(b_out_sop), .out_eop(b_out_eop), .out_mod(b_out_mod),
    .out_err(b_out_err), .out_val(b_out_val), .out_ready(b_ready),
    .pkt_cnt(b_pkt_cnt), .err_cnt(b_err_cnt), .ovf_sticky(b_ovf)
  );

  function automatic logic [63:0] word(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic s, input logic e, input logic [2:0] m,
                         input logic [63:0] d);
    a_val = v; a_sop = s; a_eop = e; a_mod = m; a_data = d;
  endtask

  task automatic do_reset();
    drive_a(0, 0, 0, 3'd0, 64'd0);
    a_ready = 0;
    b_val = 0; b_sop = 0; b_eop = 0; b_mod = 0; b_data = 0; b_ready = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val actual=%b required=0", a_out_val); end
    checks++; if (a_pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt actual=%0d required=0", a_pkt_cnt); end
    checks++; if (a_err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt actual=%0d required=0", a_err_cnt); end
    checks++; if (a_ovf !== 1'b0 || a_full !== 1'b0) begin errors++; $display("FAIL reset_ovf_full actual=%b%b required=00", a_ovf, a_full); end
    checks++; if (a_out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data actual=%h required=0", a_out_data); end
    checks++; if (b_out_val !== 1'b0 || b_pkt_cnt !== 2'd0) begin errors++; $display("FAIL reset_b actual=%b/%0d required=0/0", b_out_val, b_pkt_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    a_ready = 1;
    drive_a(1, 1, 1, 3'd0, word(100));
    tick();
    checks++; if (a_out_val !== 1'b1 || a_out_data !== word(100)) begin errors++; $display("FAIL basic_single actual=%b/%h required=1/%h", a_out_val, a_out_data, word(100)); end
    checks++; if (a_out_sop !== 1'b1 || a_out_eop !== 1'b1) begin errors++; $display("FAIL basic_single_flags actual=%b%b required=11", a_out_sop, a_out_eop); end
    drive_a(1, 1, 0, 3'd0, word(101));
    tick();
    checks++; if (a_out_data !== word(101) || a_out_sop !== 1'b1 || a_out_eop !== 1'b0) begin errors++; $display("FAIL basic_w1 actual=%h required=%h", a_out_data, word(101)); end
    drive_a(1, 0, 0, 3'd0, word(102));
    tick();
    checks++; if (a_out_val !== 1'b1 || a_out_data !== word(102)) begin errors++; $display("FAIL basic_w2 actual=%h required=%h", a_out_data, word(102)); end
    drive_a(1, 0, 1, 3'd5, word(103));
    tick();
    checks++; if (a_out_data !== word(103) || a_out_eop !== 1'b1) begin errors++; $display("FAIL basic_w3 actual=%h required=%h", a_out_data, word(103)); end
    checks++; if (a_out_mod !== 3'd5) begin errors++; $display("FAIL basic_mod actual=%0d required=5", a_out_mod); end
    drive_a(0, 0, 0, 3'd0, 64'd0);
    tick();
    checks++; if (a_out_val !== 1'b0) begin errors++; $display("FAIL basic_drained actual=%b required=0", a_out_val); end
    checks++; if (a_pkt_cnt !== 16'd2 || a_err_cnt !== 16'd0) begin errors++; $display("FAIL basic_counts actual=%0d/%0d required=2/0", a_pkt_cnt, a_err_cnt); end
  endtask

  task automatic test_full_threshold();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive_a(1, i == 0, 0, 3'd0, word(i));
      tick();
      checks++; if (a_full !== (i >= 13)) begin errors++; $display("FAIL thr_full_w%0d actual=%b required=%b", i + 1, a_full, i >= 13); end
    end
    checks++; if (a_out_data !== word(0) || a_out_sop !== 1'b1) begin errors++; $display("FAIL thr_stall_hold actual=%h required=%h", a_out_data, word(0)); end
    drive_a(0, 0, 0, 3'd0, 64'd0);
    a_ready = 1;
    tick();
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL thr_release actual=%b required=0", a_full); end
    checks++; if (a_out_data !== word(1)) begin errors++; $display("FAIL thr_next_word actual=%h required=%h", a_out_data, word(1)); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_a(1, i == 0, i == 16, 3'd0, word(i));
      tick();
      checks++; if (a_ovf !== (i == 16)) begin errors++; $display("FAIL ovf_sticky_w%0d actual=%b required=%b", i + 1, a_ovf, i == 16); end
    end
    checks++; if (a_err_cnt !== 16'd1 || a_pkt_cnt !== 16'd0) begin errors++; $display("FAIL ovf_counts actual=%0d/%0d required=1/0", a_err_cnt, a_pkt_cnt); end
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL ovf_full actual=%b required=1", a_full); end
    // Read and write at the same edge while full: the write still loses.
    drive_a(1, 1, 1, 3'd0, word(17));
    a_ready = 1;
    tick();
    drive_a(0, 0, 0, 3'd0, 64'd0);
    checks++; if (a_err_cnt !== 16'd2 || a_pkt_cnt !== 16'd0) begin errors++; $display("FAIL ovf_rw_full actual=%0d/%0d required=2/0", a_err_cnt, a_pkt_cnt); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (a_out_val !== 1'b1 || a_out_data !== word(i)) begin errors++; $display("FAIL ovf_order_%0d actual=%b/%h required=1/%h", i, a_out_val, a_out_data, word(i)); end
      tick();
    end
    checks++; if (a_out_val !== 1'b0 || a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_end actual=%b/%b required=0/1", a_out_val, a_ovf); end
  endtask

  task automatic test_framing_errors();
    do_reset();
    drive_a(1, 0, 0, 3'd0, word(50));
    tick();
    checks++; if (a_out_val !== 1'b0 || a_err_cnt !== 16'd1) begin errors++; $display("FAIL orphan actual=%b/%0d required=0/1", a_out_val, a_err_cnt); end
    drive_a(1, 1, 0, 3'd0, word(51));
    tick();
    drive_a(1, 1, 1, 3'd2, word(52));
    tick();
    drive_a(0, 0, 0, 3'd0, 64'd0);
    checks++; if (a_err_cnt !== 16'd2 || a_pkt_cnt !== 16'd1) begin errors++; $display("FAIL restart_counts actual=%0d/%0d required=2/1", a_err_cnt, a_pkt_cnt); end
    a_ready = 1;
    checks++; if (a_out_data !== word(51) || a_out_err !== 1'b0) begin errors++; $display("FAIL restart_prev actual=%h/%b required=%h/0", a_out_data, a_out_err, word(51)); end
    tick();
    checks++; if (a_out_data !== word(52) || a_out_err !== 1'b1 || a_out_sop !== 1'b1) begin errors++; $display("FAIL restart_tag actual=%h/%b/%b required=%h/1/1", a_out_data, a_out_err, a_out_sop, word(52)); end
    tick();
    checks++; if (a_out_val !== 1'b0) begin errors++; $display("FAIL restart_drained actual=%b required=0", a_out_val); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_a(1, i == 0, 0, 3'd0, word(200 + i));
      tick();
    end
    drive_a(0, 0, 0, 3'd0, 64'd0);
    reset_n = 0;
    tick();
    reset_n = 1;
    checks++; if (a_out_val !== 1'b0) begin errors++; $display("FAIL midrst_val actual=%b required=0", a_out_val); end
    checks++; if (a_pkt_cnt !== 16'd0 || a_err_cnt !== 16'd0) begin errors++; $display("FAIL midrst_counts actual=%0d/%0d required=0/0", a_pkt_cnt, a_err_cnt); end
    a_ready = 1;
    drive_a(1, 1, 1, 3'd0, word(300));
    tick();
    drive_a(0, 0, 0, 3'd0, 64'd0);
    checks++; if (a_out_data !== word(300) || a_out_err !== 1'b0 || a_out_sop !== 1'b1) begin errors++; $display("FAIL midrst_fresh actual=%h/%b required=%h/0", a_out_data, a_out_err, word(300)); end
    tick();
    checks++; if (a_err_cnt !== 16'd0 || a_pkt_cnt !== 16'd1 || a_out_val !== 1'b0) begin errors++; $display("FAIL midrst_after actual=%0d/%0d/%b required=0/1/0", a_err_cnt, a_pkt_cnt, a_out_val); end
  endtask

  task automatic test_small_wrap_saturate();
    do_reset();
    b_ready = 1;
    for (int i = 0; i < 10; i++) begin
      b_val = 1; b_sop = 1; b_eop = 1; b_mod = 2'(i); b_data = 32'hC0DE_0000 | 32'(i);
      tick();
      b_val = 0; b_sop = 0; b_eop = 0;
      checks++; if (b_out_val !== 1'b1 || b_out_data !== (32'hC0DE_0000 | 32'(i)) || b_out_mod !== 2'(i)) begin errors++; $display("FAIL wrap_word_%0d actual=%b/%h/%0d required=1/%h/%0d", i, b_out_val, b_out_data, b_out_mod, 32'hC0DE_0000 | 32'(i), i % 4); end
      tick();
    end
    checks++; if (b_pkt_cnt !== 2'd3) begin errors++; $display("FAIL sat_pkt_cnt actual=%0d required=3", b_pkt_cnt); end
    checks++; if (b_out_val !== 1'b0 || b_err_cnt !== 2'd0 || b_full !== 1'b0) begin errors++; $display("FAIL small_end actual=%b/%0d/%b required=0/0/0", b_out_val, b_err_cnt, b_full); end
  endtask

  initial begin
    a_data = 0; a_sop = 0; a_eop = 0; a_mod = 0; a_val = 0; a_ready = 0;
    b_data = 0; b_sop = 0; b_eop = 0; b_mod = 0; b_val = 0; b_ready = 0;
    #2;
    test_reset();
    test_basic();
    test_full_threshold();
    test_overflow();
    test_framing_errors();
    test_reset_mid_packet();
    test_small_wrap_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
